// File: rtl/dac_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_stream_tx
// Purpose  : Sink for the summed-sample stream. Each activein_i strobe drops
//            a signed 16-bit sample into a one-deep holding register. The
//            sample is converted to a DAC code and shifted out MSB-first as a
//            16-bit SPI-style frame (sclk_o / cs_n_o / sdo_o). A sample that
//            arrives while the holding register is still occupied is discarded
//            and counted.
// Ports    : clk_i          system clock, rising edge
//            rst_ni         asynchronous active-low reset
//            sample_i[15:0] signed sample from upstream results
//            activein_i     single-cycle valid strobe for sample_i
//            sclk_o         DAC serial clock, idles low
//            cs_n_o         DAC frame select, active-low, idles high
//            sdo_o          serial data, DAC samples on rising sclk_o
//            busy_o         holding register full or serializer not idle
//            dropped_o      one-cycle pulse per discarded sample
//            drop_count_o   saturating count of discarded samples
// Params   : CLKDIV         sclk half-period in clk cycles (1..255)
//            OFFSET_BINARY  1: invert sample MSB, 0: raw two's complement
// Revision : 1.0 - initial release
// ============================================================================
module dac_stream_tx #(
  parameter int unsigned CLKDIV        = 2,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] sample_i,
  input  logic        activein_i,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic        sdo_o,
  output logic        busy_o,
  output logic        dropped_o,
  output logic [7:0]  drop_count_o
);

  // Divider counter spans 0..2*CLKDIV-1; 9 bits covers CLKDIV up to 255.
  localparam logic [8:0] C_DIV_LAST = 9'(2 * CLKDIV - 1);
  localparam logic [8:0] C_DIV_HALF = 9'(CLKDIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] shreg_q, shreg_d;
  logic [8:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        dropped_q, dropped_d;
  logic [7:0]  drop_count_q, drop_count_d;

  logic [15:0] dac_code;
  logic [8:0]  div_inc;
  logic        xfer;

  if (OFFSET_BINARY) begin : g_offset_bin
    assign dac_code = {~hold_q[15], hold_q[14:0]};
  end else begin : g_twos_comp
    assign dac_code = hold_q;
  end

  assign div_inc = div_q + 9'd1;
  // The hold register empties into the shifter only from IDLE.
  assign xfer    = (state_q == ST_IDLE) && hold_full_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shreg_d      = shreg_q;
    div_d        = div_q;
    bit_d        = bit_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    dropped_d    = 1'b0;
    drop_count_d = drop_count_q;

    // Holding register: a transfer frees the slot in the same cycle, so a
    // coincident strobe is captured rather than dropped.
    if (activein_i && (!hold_full_q || xfer)) begin
      hold_d      = sample_i;
      hold_full_d = 1'b1;
    end else if (xfer) begin
      hold_full_d = 1'b0;
    end else if (activein_i) begin
      dropped_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shreg_d = dac_code;
          div_d   = 9'd0;
          bit_d   = 4'd0;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_q == C_DIV_LAST) begin
          // Wrap coincides with sclk falling; sdo (shreg MSB) moves here.
          // After the 16th bit the final shift leaves the register all
          // zero, which is what keeps sdo low through GAP and IDLE.
          div_d   = 9'd0;
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[14:0], 1'b0};
          if (bit_q == 4'd15) begin
            cs_n_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d  = div_inc;
          sclk_d = (div_inc >= C_DIV_HALF);
        end
      end
      ST_GAP: begin
        if (div_q == C_DIV_LAST) begin
          div_d   = 9'd0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        shreg_d = 16'h0000;
      end
    endcase

    busy_d = hold_full_d || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      hold_q       <= 16'h0000;
      hold_full_q  <= 1'b0;
      shreg_q      <= 16'h0000;
      div_q        <= 9'd0;
      bit_q        <= 4'd0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shreg_q      <= shreg_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      dropped_q    <= dropped_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign cs_n_o       = cs_n_q;
  assign sdo_o        = shreg_q[15];
  assign busy_o       = busy_q;
  assign dropped_o    = dropped_q;
  assign drop_count_o = drop_count_q;

endmodule
`default_nettype wire
